// File: rtl/ascon_permutation.sv
// Iterative ASCON permutation engine (p^12 / p^8 / p^6) with a valid/ready
// handshake on both sides. ROUNDS_PER_CYCLE rounds are chained per clock.

package ascon_pkg;
  // x0 is element 0 and also the most significant word when flattened
  typedef logic [0:4][63:0] t_state_array;

  // Round constants by round index; entries 12..15 are never addressed
  localparam logic [7:0] LUT_ADDITION [0:15] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // 5-bit S-box, column {x0,x1,x2,x3,x4} with x0 as MSB; bits [7:5] unused
  localparam logic [7:0] LUT_SBOX [0:31] = '{
    8'h04, 8'h0B, 8'h1F, 8'h14, 8'h1A, 8'h15, 8'h09, 8'h02,
    8'h1B, 8'h05, 8'h08, 8'h12, 8'h1D, 8'h03, 8'h06, 8'h1C,
    8'h1E, 8'h13, 8'h07, 8'h0E, 8'h00, 8'h0D, 8'h11, 8'h18,
    8'h10, 8'h0C, 8'h01, 8'h19, 8'h16, 8'h0A, 8'h0F, 8'h17
  };
endpackage

module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  t_state_array i_state,
  input  logic [1:0]   i_rounds,
  output logic         o_valid,
  input  logic         i_ready,
  output t_state_array o_state
);

  generate
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
      $error("ascon_permutation: ROUNDS_PER_CYCLE must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} t_fsm;

  t_fsm         fsm_q, fsm_d;
  t_state_array state_q;
  t_state_array round_out;
  logic [3:0]   r_q;
  logic [3:0]   r_next;
  logic [3:0]   r_start;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic t_state_array ascon_round(input t_state_array s_in,
                                               input logic [3:0] rc);
    t_state_array s;
    t_state_array t;
    logic [4:0]   col;
    logic [4:0]   sb;
    s = s_in;
    s[2][7:0] = s[2][7:0] ^ LUT_ADDITION[rc];
    t = '0;
    for (int j = 0; j < 64; j++) begin
      col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      sb  = LUT_SBOX[col][4:0];
      t[0][j] = sb[4];
      t[1][j] = sb[3];
      t[2][j] = sb[2];
      t[3][j] = sb[1];
      t[4][j] = sb[0];
    end
    s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
    s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
    s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
    s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
    s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    return s;
  endfunction

  // Chain the unrolled round functions for this cycle using constants r, r+1
  always_comb begin
    round_out = state_q;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      round_out = ascon_round(round_out, r_q + 4'(k));
    end
    r_next = r_q + 4'(ROUNDS_PER_CYCLE);
  end

  // Starting round index: 12 minus the requested round count (reserved = 12)
  always_comb begin
    case (i_rounds)
      2'b01:   r_start = 4'd4;
      2'b10:   r_start = 4'd6;
      default: r_start = 4'd0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  // Next-state decode
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (i_valid)           fsm_d = RUN;
      RUN:     if (r_next == 4'd12)   fsm_d = DONE;
      DONE:    if (i_ready)           fsm_d = IDLE;
      default:                        fsm_d = IDLE;
    endcase
  end

  // State register and round index: load on accept, update every RUN cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= '0;
      r_q     <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (i_valid) begin
            state_q <= i_state;
            r_q     <= r_start;
          end
        end
        RUN: begin
          state_q <= round_out;
          r_q     <= r_next;
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (fsm_q == IDLE);
  assign o_valid = (fsm_q == DONE);
  assign o_state = state_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Self-checking bench: one engine with one round per cycle, one with two,
// both compared against a bitsliced software model of the permutation.

module tb_ascon_permutation;
  import ascon_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         i_valid_a  [2];
  logic         o_ready_a  [2];
  t_state_array i_state_a  [2];
  logic [1:0]   i_rounds_a [2];
  logic         o_valid_a  [2];
  logic         i_ready_a  [2];
  t_state_array o_state_a  [2];

  int n_vec;
  int n_err;

  ascon_permutation #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (i_valid_a[0]),
    .o_ready (o_ready_a[0]),
    .i_state (i_state_a[0]),
    .i_rounds(i_rounds_a[0]),
    .o_valid (o_valid_a[0]),
    .i_ready (i_ready_a[0]),
    .o_state (o_state_a[0])
  );

  ascon_permutation #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (i_valid_a[1]),
    .o_ready (o_ready_a[1]),
    .i_state (i_state_a[1]),
    .i_rounds(i_rounds_a[1]),
    .o_valid (o_valid_a[1]),
    .i_ready (i_ready_a[1]),
    .o_state (o_state_a[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic t_state_array model_perm(input t_state_array s, input int nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    t_state_array o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    for (int r = 12 - nr; r < 12; r++) begin
      x2 = x2 ^ 64'(((15 - r) << 4) | r);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ m_ror(x0, 19) ^ m_ror(x0, 28);
      x1 = x1 ^ m_ror(x1, 61) ^ m_ror(x1, 39);
      x2 = x2 ^ m_ror(x2, 1)  ^ m_ror(x2, 6);
      x3 = x3 ^ m_ror(x3, 10) ^ m_ror(x3, 17);
      x4 = x4 ^ m_ror(x4, 7)  ^ m_ror(x4, 41);
    end
    o[0] = x0; o[1] = x1; o[2] = x2; o[3] = x3; o[4] = x4;
    return o;
  endfunction

  function automatic t_state_array rand_state();
    t_state_array s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
    return s;
  endfunction

  function automatic t_state_array kat_state();
    t_state_array s;
    s[0] = 64'h80400C0600000000;
    s[1] = 64'h0001020304050607;
    s[2] = 64'h08090A0B0C0D0E0F;
    s[3] = 64'h0001020304050607;
    s[4] = 64'h08090A0B0C0D0E0F;
    return s;
  endfunction

  // One permutation: accept, latency, data, DONE stall with i_valid ignored,
  // release. If hold_valid, next_st is left offered so the caller's next run
  // is accepted on the edge right after the return to IDLE.
  task automatic run_perm(input int sel, input t_state_array st, input logic [1:0] rs,
                          input int stall, input logic hold_valid,
                          input t_state_array next_st, input string tag);
    int nr, n_exp, cyc;
    t_state_array exp_st, held;
    nr = (rs == 2'b01) ? 8 : (rs == 2'b10) ? 6 : 12;
    n_exp = nr / (sel + 1);
    exp_st = model_perm(st, nr);

    n_vec++;
    if (o_ready_a[sel] !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, o_ready_a[sel]);
    end
    i_valid_a[sel]  = 1'b1;
    i_state_a[sel]  = st;
    i_rounds_a[sel] = rs;
    i_ready_a[sel]  = 1'b0;
    @(negedge clock);
    i_valid_a[sel]  = 1'b0;
    i_state_a[sel]  = rand_state();
    i_rounds_a[sel] = 2'($urandom_range(0, 3));
    cyc = 0;
    while (o_valid_a[sel] !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    n_vec++;
    if (cyc != n_exp) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles want %0d", tag, cyc, n_exp);
    end
    n_vec++;
    if (o_state_a[sel] !== exp_st) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", tag, o_state_a[sel], exp_st);
    end

    held = o_state_a[sel];
    for (int k = 0; k < stall; k++) begin
      i_valid_a[sel] = hold_valid;
      i_state_a[sel] = next_st;
      i_rounds_a[sel] = 2'($urandom_range(0, 3));
      @(negedge clock);
      n_vec++;
      if (o_valid_a[sel] !== 1'b1 || o_ready_a[sel] !== 1'b0 || o_state_a[sel] !== held) begin
        n_err++;
        $display("FAIL %s stall_hold cyc%0d: got v=%b r=%b st=%h want v=1 r=0 st=%h",
                 tag, k, o_valid_a[sel], o_ready_a[sel], o_state_a[sel], held);
      end
    end

    i_valid_a[sel] = hold_valid;
    i_state_a[sel] = next_st;
    i_ready_a[sel] = 1'b1;
    @(negedge clock);
    i_ready_a[sel] = 1'b0;
    n_vec++;
    if (o_ready_a[sel] !== 1'b1 || o_valid_a[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: got r=%b v=%b want r=1 v=0", tag, o_ready_a[sel], o_valid_a[sel]);
    end
    if (!hold_valid) i_valid_a[sel] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      i_valid_a[s]  = 1'b1;
      i_state_a[s]  = rand_state();
      i_rounds_a[s] = 2'b10;
      i_ready_a[s]  = 1'b0;
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    i_valid_a[0] = 1'b0;
    i_valid_a[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if (o_ready_a[s] !== 1'b1 || o_valid_a[s] !== 1'b0 || o_state_a[s] !== '0) begin
        n_err++;
        $display("FAIL reset dut%0d: got r=%b v=%b st=%h want r=1 v=0 st=0",
                 s, o_ready_a[s], o_valid_a[s], o_state_a[s]);
      end
    end
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if (o_ready_a[s] !== 1'b1 || o_state_a[s] !== '0) begin
        n_err++;
        $display("FAIL reset_no_accept dut%0d: got r=%b st=%h want r=1 st=0",
                 s, o_ready_a[s], o_state_a[s]);
      end
    end
  endtask

  task automatic test_kat_rounds();
    run_perm(0, kat_state(), 2'b00, 0, 1'b0, '0, "kat_p12");
    run_perm(0, kat_state(), 2'b01, 0, 1'b0, '0, "kat_p8");
    run_perm(0, kat_state(), 2'b10, 0, 1'b0, '0, "kat_p6");
    run_perm(0, kat_state(), 2'b11, 0, 1'b0, '0, "kat_reserved");
    run_perm(1, kat_state(), 2'b00, 0, 1'b0, '0, "kat2_p12");
    run_perm(1, kat_state(), 2'b10, 0, 1'b0, '0, "kat2_p6");
  endtask

  task automatic test_backpressure();
    t_state_array nxt;
    nxt = rand_state();
    run_perm(0, kat_state(), 2'b00, 20, 1'b1, nxt, "bp_first");
    run_perm(0, nxt, 2'b01, 0, 1'b0, '0, "bp_second");
  endtask

  task automatic test_mid_reset();
    n_vec++;
    if (o_ready_a[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_ready: got %b want 1", o_ready_a[0]);
    end
    i_valid_a[0]  = 1'b1;
    i_state_a[0]  = rand_state();
    i_rounds_a[0] = 2'b00;
    @(negedge clock);
    i_valid_a[0] = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      n_vec++;
      if (o_valid_a[0] !== 1'b0 || o_ready_a[0] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_running cyc%0d: got v=%b r=%b want v=0 r=0", k, o_valid_a[0], o_ready_a[0]);
      end
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    n_vec++;
    if (o_ready_a[0] !== 1'b1 || o_valid_a[0] !== 1'b0 || o_state_a[0] !== '0) begin
      n_err++;
      $display("FAIL midrst_cleared: got r=%b v=%b st=%h want r=1 v=0 st=0",
               o_ready_a[0], o_valid_a[0], o_state_a[0]);
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      n_vec++;
      if (o_valid_a[0] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_no_result cyc%0d: got v=%b want 0", k, o_valid_a[0]);
      end
    end
    run_perm(0, rand_state(), 2'b10, 0, 1'b0, '0, "midrst_after_p6");
  endtask

  task automatic test_random(input int sel, input int count);
    t_state_array cur, nxt;
    logic hold;
    cur = rand_state();
    for (int i = 0; i < count; i++) begin
      nxt  = rand_state();
      hold = (i < count - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_perm(sel, cur, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
               hold, nxt, (sel == 0) ? "rand_rpc1" : "rand_rpc2");
      if (!hold) begin
        if ($urandom_range(0, 1) == 1) @(negedge clock);
      end
      cur = nxt;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      i_valid_a[s] = 1'b0; i_state_a[s] = '0; i_rounds_a[s] = 2'b00; i_ready_a[s] = 1'b0;
    end
    @(negedge clock);
    test_reset();
    test_kat_rounds();
    test_backpressure();
    test_mid_reset();
    test_random(0, 150);
    test_random(1, 1000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_permutation.md
# ascon_permutation

Iterative ASCON permutation engine: accepts a 320-bit state, applies p^12, p^8 or p^6 rounds (constant addition, 5-bit S-box substitution, linear diffusion) and returns the permuted state over a valid/ready handshake. It consumes the round-constant and S-box tables and the `t_state_array` type from `ascon_pkg`. It sits between the mode controller (initialization, associated data, plaintext, finalization sequencing) and the state register file.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds unrolled per clock. Legal values are 1 or 2; any other value is an elaboration error.
- `clock` in 1: single clock. All logic on the rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `i_valid` in 1: input state and round selection present.
- `o_ready` out 1: engine idle and able to accept.
- `i_state` in `t_state_array` (5×64): state x0..x4 to permute.
- `i_rounds` in 2: 00 = 12 rounds, 01 = 8, 10 = 6, 11 = reserved (treated as 12).
- `o_valid` out 1: `o_state` holds the permuted result.
- `i_ready` in 1: consumer accepts the result.
- `o_state` out `t_state_array`: permutation result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: `o_ready`=1. On `i_valid && o_ready`, latch `i_state` into the state register, set the round index `r` to 12−n (0, 4 or 6), and go to RUN.
- RUN: each cycle applies `ROUNDS_PER_CYCLE` rounds and advances `r` by the same amount. When the updated `r` equals 12, go to DONE.
- DONE: `o_valid`=1. `o_state` and `o_valid` are held stable until `i_ready`=1, then go to IDLE. `i_valid` is ignored outside IDLE.
- Round r, constant addition: x2[7:0] ^= `LUT_ADDITION[r]`. The table uses ascending indices, so index 0 = 0xF0 and index 11 = 0x4B.
- Substitution: for each bit position j in 0..63, form the column {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as the MSB. Replace it with `LUT_SBOX[col][4:0]`, where index 0 = 0x04. Bits [7:5] of the table entry are unused.
- Linear diffusion, where ror = rotate right:
  - x0 ^= ror(x0,19)^ror(x0,28)
  - x1 ^= ror(x1,61)^ror(x1,39)
  - x2 ^= ror(x2,1)^ror(x2,6)
  - x3 ^= ror(x3,10)^ror(x3,17)
  - x4 ^= ror(x4,7)^ror(x4,41)
- With `ROUNDS_PER_CYCLE`=2, two round functions are chained combinationally using constants r and r+1. The round counts 12, 8 and 6 are all even, so no partial step occurs.
- `r` is a 4-bit register. It never exceeds 12 and never wraps.
- `i_rounds`=11 behaves exactly like 00.

## Timing
- Reset values: `o_ready`=1 (IDLE), `o_valid`=0, `o_state`=all zero, `r`=0.
- `o_ready` and `o_valid` are decoded from registered FSM state only; there is no combinational path from `i_valid` or `i_ready`.
- Latency: the accept edge is cycle 0. RUN occupies cycles 1..N, where N = rounds/`ROUNDS_PER_CYCLE`. `o_valid` rises after the N-th RUN edge.
  - Example: p^12 with `ROUNDS_PER_CYCLE`=1 gives `o_valid` high 12 cycles after accept.
  - Example: p^6 with `ROUNDS_PER_CYCLE`=2 gives 3 cycles.
- Throughput: with `i_ready` held at 1, one permutation per N+2 cycles. The engine spends one cycle in DONE and one in IDLE before the next accept.
- `i_ready` low in DONE: outputs are held for any number of cycles. The state register does not change.
- `reset_n` low in any state, including mid-RUN or DONE with `o_valid` high: the next edge forces IDLE, clears the state register to zero and drops `o_valid`. No partial result is emitted.
- `i_valid` high on the same edge that `reset_n` is low: reset wins and the input is not latched.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `i_valid`=1 -> `o_ready`=1, `o_valid`=0, `o_state`=0 after release, and no accept during reset.
- p^12 latency and data, `ROUNDS_PER_CYCLE`=1: `i_state`={0x80400C0600000000, key 0x000102030405060708090A0B0C0D0E0F, nonce 0x000102030405060708090A0B0C0D0E0F}, `i_rounds`=00 -> `o_valid` exactly 12 cycles after accept, and `o_state` equals the golden C model bitwise.
- Round selection: same state with `i_rounds`=01, 10 and 11 -> `o_valid` after 8, 6 and 12 cycles, each output matching the golden model for p^8, p^6 and p^12.
- Backpressure: hold `i_ready`=0 for 20 cycles in DONE while driving `i_valid`=1 with new data -> `o_state` stable, `o_ready`=0, no second accept. Raising `i_ready` returns to IDLE, and the next accept occurs 1 cycle later.
- Mid-operation reset: assert `reset_n`=0 on cycle 5 of a p^12 run -> IDLE next edge, `o_valid` never asserted, `o_state`=0. A following p^6 run gives a correct result.
- `ROUNDS_PER_CYCLE`=2 build: 1000 random states × random `i_rounds`, random `i_ready` stalls -> latency = rounds/2 for each, and all outputs match the golden model.
